sparse_chunk_tx: RTL and testbench

- Transmit side of the sparse chunk write interface consumed by the compute cluster's IFM and filter input buffers.
- Accepts a dense chunk of MEM_SIZE bytes, BUS_SIZE bytes per beat, and builds its sparse map plus a front-packed non-zero data array.
- Streams the chunk out as MEM_SIZE/BUS_SIZE beats using the cluster's wr_valid / wr_count / sparsemap / nonzero_data convention, then toggles the double-buffer select.
- Replaces the bench-side generator for system-level runs.

---
 rtl/sparse_tx_pkg.sv | 19 +
 rtl/sparse_beat_compactor.sv | 28 ++
 rtl/sparse_chunk_tx.sv | 174 +++++++++++++++++
 tb/tb_sparse_chunk_tx.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sparse_tx_pkg.sv
// Shared types and sizing helpers for the sparse chunk transmitter.
package sparse_tx_pkg;

    typedef enum logic [1:0] {FILL, READY, SEND} tx_state_e;

    function automatic int unsigned nbeat(input int unsigned mem_size, input int unsigned bus_size);
        return mem_size / bus_size;
    endfunction

    function automatic int unsigned ptr_w(input int unsigned mem_size);
        return $clog2(mem_size) + 1;
    endfunction

    // Beat-index width, kept at least 1 bit for single-beat chunks
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sparse_beat_compactor.sv
// Per-beat zero detection: byte map, prefix offsets of non-zero bytes, and popcount.
module sparse_beat_compactor #(
    parameter int unsigned BUS_SIZE = 8,
    parameter int unsigned OFS_W    = $clog2(BUS_SIZE + 1)
) (
    input  logic [BUS_SIZE*8-1:0]           data_i,
    output logic [BUS_SIZE-1:0]             map_o,
    output logic [BUS_SIZE-1:0][OFS_W-1:0]  prefix_o,
    output logic [OFS_W-1:0]                popcount_o
);

    always_comb begin
        logic [OFS_W-1:0] acc;
        logic             nz;
        acc      = '0;
        nz       = 1'b0;
        map_o    = '0;
        prefix_o = '0;
        for (int i = 0; i < BUS_SIZE; i++) begin
            nz          = |data_i[8*i +: 8];
            map_o[i]    = nz;
            prefix_o[i] = acc;
            acc         = acc + OFS_W'(nz);
        end
        popcount_o = acc;
    end

endmodule

// File: rtl/sparse_chunk_tx.sv
// Collects a dense chunk, builds its sparse map and front-packed non-zero bytes,
// then streams them out beat by beat and flips the consumer's double-buffer select.
module sparse_chunk_tx
    import sparse_tx_pkg::*;
#(
    parameter int unsigned MEM_SIZE = 128,
    parameter int unsigned BUS_SIZE = 8,
    localparam int unsigned NBEAT   = nbeat(MEM_SIZE, BUS_SIZE),
    localparam int unsigned PTR_W   = ptr_w(MEM_SIZE),
    localparam int unsigned CNT_W   = cnt_w(NBEAT)
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  din_valid_i,
    output logic                  din_ready_o,
    input  logic [BUS_SIZE*8-1:0] din_data_i,
    input  logic                  tx_grant_i,
    output logic                  wr_valid_o,
    output logic [CNT_W-1:0]      wr_count_o,
    output logic [BUS_SIZE-1:0]   sparsemap_o,
    output logic [BUS_SIZE*8-1:0] nonzero_data_o,
    output logic                  wr_sel_o,
    output logic [PTR_W-1:0]      nz_count_o,
    output logic                  tx_done_o
);

    localparam int unsigned OFS_W = $clog2(BUS_SIZE + 1);
    localparam int unsigned AW    = (PTR_W > 1) ? PTR_W - 1 : 1;

    tx_state_e                   state_q, state_d;
    logic [MEM_SIZE-1:0]         map_q, map_d;
    logic [MEM_SIZE-1:0][7:0]    nz_buf_q, nz_buf_d;
    logic [PTR_W-1:0]            wptr_q, wptr_d;
    logic [CNT_W-1:0]            beat_q, beat_d;
    logic                        wr_valid_q, wr_valid_d;
    logic [CNT_W-1:0]            wr_count_q, wr_count_d;
    logic [BUS_SIZE-1:0]         sparsemap_q, sparsemap_d;
    logic [BUS_SIZE*8-1:0]       nonzero_q, nonzero_d;
    logic                        wr_sel_q, wr_sel_d;
    logic                        tx_done_q, tx_done_d;

    logic [BUS_SIZE-1:0]             beat_map;
    logic [BUS_SIZE-1:0][OFS_W-1:0]  beat_prefix;
    logic [OFS_W-1:0]                beat_pop;

    sparse_beat_compactor #(
        .BUS_SIZE (BUS_SIZE),
        .OFS_W    (OFS_W)
    ) u_compactor (
        .data_i     (din_data_i),
        .map_o      (beat_map),
        .prefix_o   (beat_prefix),
        .popcount_o (beat_pop)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= FILL;
            map_q       <= '0;
            nz_buf_q    <= '0;
            wptr_q      <= '0;
            beat_q      <= '0;
            wr_valid_q  <= 1'b0;
            wr_count_q  <= '0;
            sparsemap_q <= '0;
            nonzero_q   <= '0;
            wr_sel_q    <= 1'b0;
            tx_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            map_q       <= map_d;
            nz_buf_q    <= nz_buf_d;
            wptr_q      <= wptr_d;
            beat_q      <= beat_d;
            wr_valid_q  <= wr_valid_d;
            wr_count_q  <= wr_count_d;
            sparsemap_q <= sparsemap_d;
            nonzero_q   <= nonzero_d;
            wr_sel_q    <= wr_sel_d;
            tx_done_q   <= tx_done_d;
        end
    end

    always_comb begin
        logic [PTR_W-1:0] idx;
        logic             load;
        logic [CNT_W-1:0] load_cnt;
        state_d     = state_q;
        map_d       = map_q;
        nz_buf_d    = nz_buf_q;
        wptr_d      = wptr_q;
        beat_d      = beat_q;
        wr_valid_d  = wr_valid_q;
        wr_count_d  = wr_count_q;
        sparsemap_d = sparsemap_q;
        nonzero_d   = nonzero_q;
        wr_sel_d    = wr_sel_q;
        tx_done_d   = 1'b0;
        idx         = '0;
        load        = 1'b0;
        load_cnt    = '0;

        unique case (state_q)
            FILL: begin
                if (din_valid_i) begin
                    for (int b = 0; b < NBEAT; b++) begin
                        if (beat_q == CNT_W'(b)) map_d[b*BUS_SIZE +: BUS_SIZE] = beat_map;
                    end
                    for (int i = 0; i < BUS_SIZE; i++) begin
                        idx = wptr_q + PTR_W'(beat_prefix[i]);
                        if (beat_map[i] && idx < PTR_W'(MEM_SIZE)) begin
                            nz_buf_d[idx[AW-1:0]] = din_data_i[8*i +: 8];
                        end
                    end
                    wptr_d = wptr_q + PTR_W'(beat_pop);
                    beat_d = beat_q + CNT_W'(1);
                    if (beat_q == CNT_W'(NBEAT - 1)) begin
                        beat_d  = '0;
                        state_d = READY;
                    end
                end
            end
            READY: begin
                if (tx_grant_i) begin
                    state_d    = SEND;
                    wr_valid_d = 1'b1;
                    wr_count_d = '0;
                    tx_done_d  = (NBEAT == 1);
                    load       = 1'b1;
                end
            end
            SEND: begin
                if (wr_count_q == CNT_W'(NBEAT - 1)) begin
                    // Last beat ends: clear the chunk so stale bytes never reach the next one
                    state_d     = FILL;
                    wr_valid_d  = 1'b0;
                    wr_count_d  = '0;
                    wr_sel_d    = ~wr_sel_q;
                    map_d       = '0;
                    nz_buf_d    = '0;
                    wptr_d      = '0;
                    beat_d      = '0;
                    sparsemap_d = '0;
                    nonzero_d   = '0;
                end else begin
                    load_cnt   = wr_count_q + CNT_W'(1);
                    wr_count_d = load_cnt;
                    tx_done_d  = (load_cnt == CNT_W'(NBEAT - 1));
                    load       = 1'b1;
                end
            end
            default: state_d = FILL;
        endcase

        if (load) begin
            for (int b = 0; b < NBEAT; b++) begin
                if (load_cnt == CNT_W'(b)) begin
                    sparsemap_d = map_q[b*BUS_SIZE +: BUS_SIZE];
                    nonzero_d   = nz_buf_q[b*BUS_SIZE +: BUS_SIZE];
                end
            end
        end
    end

    assign din_ready_o    = (state_q == FILL);
    assign wr_valid_o     = wr_valid_q;
    assign wr_count_o     = wr_count_q;
    assign sparsemap_o    = sparsemap_q;
    assign nonzero_data_o = nonzero_q;
    assign wr_sel_o       = wr_sel_q;
    assign nz_count_o     = wptr_q;
    assign tx_done_o      = tx_done_q;

endmodule

// File: tb/tb_sparse_chunk_tx.sv
// Directed bench for sparse_chunk_tx at default sizing (128-byte chunk, 8-byte beats).
module tb_sparse_chunk_tx;

    localparam int MEM = 128;
    localparam int BUS = 8;
    localparam int NB  = 16;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        din_valid = 1'b0;
    logic        tx_grant = 1'b0;
    logic [63:0] din_data = '0;
    logic        din_ready, wr_valid, wr_sel, tx_done;
    logic [3:0]  wr_count;
    logic [7:0]  sparsemap, nz_count;
    logic [63:0] nonzero_data;

    sparse_chunk_tx #(
        .MEM_SIZE (MEM),
        .BUS_SIZE (BUS)
    ) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .din_valid_i    (din_valid),
        .din_ready_o    (din_ready),
        .din_data_i     (din_data),
        .tx_grant_i     (tx_grant),
        .wr_valid_o     (wr_valid),
        .wr_count_o     (wr_count),
        .sparsemap_o    (sparsemap),
        .nonzero_data_o (nonzero_data),
        .wr_sel_o       (wr_sel),
        .nz_count_o     (nz_count),
        .tx_done_o      (tx_done)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    logic [7:0]  chunk [MEM];
    logic [7:0]  exp_map [NB];
    logic [63:0] exp_nz [NB];
    int          exp_cnt;
    logic        exp_sel;

    logic        got_valid [NB];
    logic        got_done [NB];
    logic        got_sel [NB];
    logic [3:0]  got_cnt [NB];
    logic [7:0]  got_map [NB];
    logic [63:0] got_nz [NB];
    logic [7:0]  got_nzc;
    logic        post_valid, post_sel;
    logic [3:0]  post_cnt;

    // Reference: sequential pack of non-zero bytes in address order
    task automatic build_expected();
        logic [7:0] pk [MEM];
        int n;
        n = 0;
        for (int i = 0; i < MEM; i++) pk[i] = 8'h00;
        for (int i = 0; i < MEM; i++) begin
            exp_map[i/8][i%8] = (chunk[i] != 8'h00);
            if (chunk[i] != 8'h00) begin
                pk[n] = chunk[i];
                n++;
            end
        end
        for (int k = 0; k < NB; k++)
            for (int b = 0; b < BUS; b++) exp_nz[k][8*b +: 8] = pk[8*k+b];
        exp_cnt = n;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        din_valid = 1'b0;
        tx_grant = 1'b0;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        exp_sel = 1'b0;
    endtask

    task automatic drive_chunk(input bit stall, input bit grant_noise);
        for (int k = 0; k < NB; k++) begin
            @(negedge CLK);
            if (stall && (k % 2 == 1)) begin
                din_valid = 1'b0;
                din_data = '1;
                @(negedge CLK);
            end
            din_valid = 1'b1;
            tx_grant = grant_noise;
            for (int b = 0; b < BUS; b++) din_data[8*b +: 8] = chunk[8*k+b];
        end
        @(negedge CLK);
        din_valid = 1'b0;
        din_data = '0;
        tx_grant = 1'b0;
    endtask

    // Grant for one cycle, then record the fixed 16-beat window and the cycle after it
    task automatic collect();
        tx_grant = 1'b1;
        @(negedge CLK);
        tx_grant = 1'b0;
        got_nzc = nz_count;
        for (int c = 0; c < NB; c++) begin
            got_valid[c] = wr_valid;
            got_cnt[c] = wr_count;
            got_map[c] = sparsemap;
            got_nz[c] = nonzero_data;
            got_done[c] = tx_done;
            got_sel[c] = wr_sel;
            @(negedge CLK);
        end
        post_valid = wr_valid;
        post_cnt = wr_count;
        post_sel = wr_sel;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (din_ready !== 1'b1) begin errors++; $display("FAIL reset_din_ready got %b want 1", din_ready); end
        checks++; if (wr_valid !== 1'b0) begin errors++; $display("FAIL reset_wr_valid got %b want 0", wr_valid); end
        checks++; if (wr_count !== 4'd0) begin errors++; $display("FAIL reset_wr_count got %0d want 0", wr_count); end
        checks++; if (wr_sel !== 1'b0) begin errors++; $display("FAIL reset_wr_sel got %b want 0", wr_sel); end
        checks++; if (tx_done !== 1'b0) begin errors++; $display("FAIL reset_tx_done got %b want 0", tx_done); end
        checks++; if (nz_count !== 8'd0) begin errors++; $display("FAIL reset_nz_count got %0d want 0", nz_count); end
        checks++; if (sparsemap !== 8'h00) begin errors++; $display("FAIL reset_sparsemap got %h want 00", sparsemap); end
        checks++; if (nonzero_data !== 64'h0) begin errors++; $display("FAIL reset_nonzero got %h want 0", nonzero_data); end
    endtask

    task automatic test_all_zero();
        for (int i = 0; i < MEM; i++) chunk[i] = 8'h00;
        build_expected();
        drive_chunk(1'b0, 1'b0);
        checks++; if (din_ready !== 1'b0) begin errors++; $display("FAIL zero_ready_state got %b want 0", din_ready); end
        collect();
        checks++; if (got_nzc !== 8'd0) begin errors++; $display("FAIL zero_nz_count got %0d want 0", got_nzc); end
        for (int c = 0; c < NB; c++) begin
            checks++; if (got_valid[c] !== 1'b1) begin errors++; $display("FAIL zero_valid beat %0d got %b want 1", c, got_valid[c]); end
            checks++; if (got_cnt[c] !== 4'(c)) begin errors++; $display("FAIL zero_count beat %0d got %0d want %0d", c, got_cnt[c], c); end
            checks++; if (got_map[c] !== 8'h00) begin errors++; $display("FAIL zero_map beat %0d got %h want 00", c, got_map[c]); end
            checks++; if (got_nz[c] !== 64'h0) begin errors++; $display("FAIL zero_data beat %0d got %h want 0", c, got_nz[c]); end
            checks++; if (got_done[c] !== (c == NB - 1)) begin errors++; $display("FAIL zero_done beat %0d got %b want %b", c, got_done[c], c == NB - 1); end
            checks++; if (got_sel[c] !== exp_sel) begin errors++; $display("FAIL zero_sel beat %0d got %b want %b", c, got_sel[c], exp_sel); end
        end
        checks++; if (post_valid !== 1'b0) begin errors++; $display("FAIL zero_post_valid got %b want 0", post_valid); end
        checks++; if (post_cnt !== 4'd0) begin errors++; $display("FAIL zero_post_count got %0d want 0", post_cnt); end
        checks++; if (post_sel !== ~exp_sel) begin errors++; $display("FAIL zero_post_sel got %b want %b", post_sel, ~exp_sel); end
        exp_sel = ~exp_sel;
    endtask

    task automatic test_all_dense();
        for (int i = 0; i < MEM; i++) chunk[i] = 8'(i + 1);
        build_expected();
        drive_chunk(1'b0, 1'b0);
        collect();
        checks++; if (got_nzc !== 8'd128) begin errors++; $display("FAIL dense_nz_count got %0d want 128", got_nzc); end
        checks++; if (got_nz[0] !== 64'h0807060504030201) begin errors++; $display("FAIL dense_beat0 got %h want 0807060504030201", got_nz[0]); end
        checks++; if (got_nz[15] !== 64'h807F7E7D7C7B7A79) begin errors++; $display("FAIL dense_beat15 got %h want 807f7e7d7c7b7a79", got_nz[15]); end
        for (int c = 0; c < NB; c++) begin
            checks++; if (got_map[c] !== 8'hFF) begin errors++; $display("FAIL dense_map beat %0d got %h want ff", c, got_map[c]); end
            checks++; if (got_nz[c] !== exp_nz[c]) begin errors++; $display("FAIL dense_data beat %0d got %h want %h", c, got_nz[c], exp_nz[c]); end
            checks++; if (got_sel[c] !== exp_sel) begin errors++; $display("FAIL dense_sel beat %0d got %b want %b", c, got_sel[c], exp_sel); end
        end
        checks++; if (post_sel !== ~exp_sel) begin errors++; $display("FAIL dense_post_sel got %b want %b", post_sel, ~exp_sel); end
        exp_sel = ~exp_sel;
    endtask

    task automatic test_sparse_beat0();
        for (int i = 0; i < MEM; i++) chunk[i] = 8'h00;
        chunk[1] = 8'd5;
        chunk[3] = 8'd7;
        chunk[7] = 8'd9;
        build_expected();
        drive_chunk(1'b0, 1'b0);
        collect();
        checks++; if (got_nzc !== 8'd3) begin errors++; $display("FAIL sparse_nz_count got %0d want 3", got_nzc); end
        checks++; if (got_map[0] !== 8'b1000_1010) begin errors++; $display("FAIL sparse_map0 got %b want 10001010", got_map[0]); end
        checks++; if (got_nz[0] !== 64'h0000_0000_0009_0705) begin errors++; $display("FAIL sparse_data0 got %h want 90705", got_nz[0]); end
        for (int c = 1; c < NB; c++) begin
            checks++; if (got_map[c] !== 8'h00 || got_nz[c] !== 64'h0) begin
                errors++; $display("FAIL sparse_rest beat %0d got map %h data %h want 0", c, got_map[c], got_nz[c]);
            end
        end
        exp_sel = ~exp_sel;
    endtask

    task automatic test_cross_beat();
        for (int i = 0; i < MEM; i++) chunk[i] = 8'h00;
        for (int i = 1; i < 10; i++) chunk[i] = 8'(i);
        build_expected();
        drive_chunk(1'b1, 1'b0);
        collect();
        checks++; if (got_nzc !== 8'd9) begin errors++; $display("FAIL cross_nz_count got %0d want 9", got_nzc); end
        checks++; if (got_map[0] !== 8'hFE) begin errors++; $display("FAIL cross_map0 got %h want fe", got_map[0]); end
        checks++; if (got_map[1] !== 8'h03) begin errors++; $display("FAIL cross_map1 got %h want 03", got_map[1]); end
        checks++; if (got_nz[0] !== 64'h0807060504030201) begin errors++; $display("FAIL cross_data0 got %h want 0807060504030201", got_nz[0]); end
        checks++; if (got_nz[1] !== 64'h09) begin errors++; $display("FAIL cross_data1 got %h want 09", got_nz[1]); end
        for (int c = 2; c < NB; c++) begin
            checks++; if (got_nz[c] !== exp_nz[c] || got_map[c] !== exp_map[c]) begin
                errors++; $display("FAIL cross_rest beat %0d got map %h data %h want 0", c, got_map[c], got_nz[c]);
            end
        end
        exp_sel = ~exp_sel;
    endtask

    task automatic test_grant_hold();
        do_reset();
        for (int i = 0; i < MEM; i++) chunk[i] = (i % 3 == 0) ? 8'h00 : 8'(i);
        build_expected();
        drive_chunk(1'b0, 1'b1);
        for (int c = 0; c < 20; c++) begin
            checks++; if (wr_valid !== 1'b0 || din_ready !== 1'b0) begin
                errors++; $display("FAIL hold cycle %0d got valid %b ready %b want 0 0", c, wr_valid, din_ready);
            end
            @(negedge CLK);
        end
        collect();
        checks++; if (got_nzc !== 8'(exp_cnt)) begin errors++; $display("FAIL hold_nz_count got %0d want %0d", got_nzc, exp_cnt); end
        for (int c = 0; c < NB; c++) begin
            checks++; if (got_valid[c] !== 1'b1 || got_cnt[c] !== 4'(c)) begin
                errors++; $display("FAIL hold_beat %0d got valid %b count %0d want 1 %0d", c, got_valid[c], got_cnt[c], c);
            end
            checks++; if (got_map[c] !== exp_map[c] || got_nz[c] !== exp_nz[c]) begin
                errors++; $display("FAIL hold_data beat %0d got %h/%h want %h/%h", c, got_map[c], got_nz[c], exp_map[c], exp_nz[c]);
            end
        end
        checks++; if (got_sel[0] !== 1'b0) begin errors++; $display("FAIL b2b_sel_first got %b want 0", got_sel[0]); end
        checks++; if (post_valid !== 1'b0) begin errors++; $display("FAIL hold_post_valid got %b want 0", post_valid); end
        for (int i = 0; i < MEM; i++) chunk[i] = 8'(255 - i);
        build_expected();
        drive_chunk(1'b0, 1'b0);
        collect();
        checks++; if (got_sel[0] !== 1'b1) begin errors++; $display("FAIL b2b_sel_second got %b want 1", got_sel[0]); end
        checks++; if (post_sel !== 1'b0) begin errors++; $display("FAIL b2b_sel_third got %b want 0", post_sel); end
        checks++; if (got_nz[NB-1] !== exp_nz[NB-1]) begin errors++; $display("FAIL b2b_last_data got %h want %h", got_nz[NB-1], exp_nz[NB-1]); end
        exp_sel = 1'b0;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < MEM; i++) chunk[i] = 8'(i + 1);
        drive_chunk(1'b0, 1'b0);
        tx_grant = 1'b1;
        @(negedge CLK);
        tx_grant = 1'b0;
        repeat (5) @(negedge CLK);
        checks++; if (wr_count !== 4'd5 || wr_valid !== 1'b1) begin
            errors++; $display("FAIL mid_pre_reset got count %0d valid %b want 5 1", wr_count, wr_valid);
        end
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        exp_sel = 1'b0;
        checks++; if (wr_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %b want 0", wr_valid); end
        checks++; if (wr_sel !== 1'b0) begin errors++; $display("FAIL mid_sel got %b want 0", wr_sel); end
        checks++; if (din_ready !== 1'b1) begin errors++; $display("FAIL mid_ready got %b want 1", din_ready); end
        checks++; if (nz_count !== 8'd0) begin errors++; $display("FAIL mid_nz_count got %0d want 0", nz_count); end
        @(negedge CLK);
        checks++; if (wr_valid !== 1'b0) begin errors++; $display("FAIL mid_no_partial got %b want 0", wr_valid); end
        for (int i = 0; i < MEM; i++) chunk[i] = 8'h00;
        drive_chunk(1'b0, 1'b0);
        collect();
        checks++; if (got_nzc !== 8'd0) begin errors++; $display("FAIL mid_new_nz_count got %0d want 0", got_nzc); end
        for (int c = 0; c < NB; c++) begin
            checks++; if (got_map[c] !== 8'h00 || got_nz[c] !== 64'h0 || got_cnt[c] !== 4'(c)) begin
                errors++; $display("FAIL mid_stale beat %0d got map %h data %h count %0d want 0 0 %0d", c, got_map[c], got_nz[c], got_cnt[c], c);
            end
        end
        checks++; if (got_sel[0] !== 1'b0 || post_sel !== 1'b1) begin
            errors++; $display("FAIL mid_sel_seq got %b,%b want 0,1", got_sel[0], post_sel);
        end
    endtask

    initial begin
        test_reset();
        test_all_zero();
        test_all_dense();
        test_sparse_beat0();
        test_cross_beat();
        test_grant_hold();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
